// File: rtl/burst_memory_responder.sv
// burst_memory_responder: 4-beat 64-bit burst memory endpoint; BURST_MEMORY_RESPONDER_STATS_EN adds burst counters
module burst_memory_responder #(
  parameter int LINE_IDX_BITS = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
`ifdef BURST_MEMORY_RESPONDER_STATS_EN
  ,output logic [31:0] read_count_o,
  output logic [31:0] write_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} state_t;
  state_t r_state, w_state_n;
  logic r_op;
  logic [LINE_IDX_BITS-1:0] r_idx;
  logic [3:0] r_cnt;
  logic [1:0] r_beat;
  logic [255:0] r_rbuf;
  logic [255:0] r_mem [2**LINE_IDX_BITS];
  logic w_req, w_accept, w_load, w_wr_en, w_done;
  logic [LINE_IDX_BITS-1:0] w_idx;
  logic w_unused;
  assign w_unused = ^{address_i[31:5+LINE_IDX_BITS], address_i[4:0]};
  assign w_idx = (r_state == IDLE) ? address_i[5 +: LINE_IDX_BITS] : r_idx;
  assign resp_o = (r_state == BURST);
  assign burst_o = (resp_o && !r_op) ? r_rbuf[64*r_beat +: 64] : 64'd0;
  always_comb begin
    w_state_n = r_state;
    w_accept = 1'b0;
    w_load = 1'b0;
    w_wr_en = 1'b0;
    w_done = 1'b0;
    w_req = r_op ? write_i : read_i;
    case (r_state)
      IDLE: if (read_i || write_i) begin
        w_accept = 1'b1;
        w_state_n = (LATENCY == 1) ? BURST : WAIT;
        w_load = (LATENCY == 1) && read_i;
      end
      WAIT: if (!w_req) w_state_n = IDLE;
        else if (r_cnt == 4'd1) begin
          w_state_n = BURST;
          w_load = !r_op;
        end
      BURST: if (!w_req) w_state_n = IDLE;
        else begin
          w_wr_en = r_op;
          if (r_beat == 2'd3) begin
            w_state_n = RECOVER;
            w_done = 1'b1;
          end
        end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op <= 1'b0;
      r_idx <= '0;
      r_cnt <= 4'd0;
      r_beat <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_beat <= (r_state == BURST) ? r_beat + 2'd1 : 2'd0;
      r_cnt <= w_accept ? 4'(LATENCY - 1) : (r_state == WAIT) ? r_cnt - 4'd1 : r_cnt;
      if (w_accept) begin
        r_op <= !read_i;
        r_idx <= w_idx;
      end
      if (w_load) r_rbuf <= r_mem[w_idx];
    end
  end
  // the store is never cleared; reset only blocks the write on its own edge
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) r_mem[r_idx][64*r_beat +: 64] <= burst_i;
  end
`ifdef BURST_MEMORY_RESPONDER_STATS_EN
  logic [31:0] r_rd_cnt, r_wr_cnt;
  assign read_count_o = r_rd_cnt;
  assign write_count_o = r_wr_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= 32'd0;
      r_wr_cnt <= 32'd0;
    end else if (w_done) begin
      r_rd_cnt <= r_rd_cnt + {31'd0, !r_op};
      r_wr_cnt <= r_wr_cnt + {31'd0, r_op};
    end
  end
`endif
endmodule
